// File: rtl/bist_misr_checker.sv
// Response compactor and golden-signature compare stage behind the BIST controller.
// Compacts the CUT output word into a Fibonacci MISR and reports a sticky verdict on finish.
module bist_misr_checker #(
  parameter int               WIDTH  = 8,
  parameter logic [WIDTH-1:0] POLY   = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] SEED   = WIDTH'(8'h01),
  parameter logic [WIDTH-1:0] GOLDEN = WIDTH'(8'h00),
  parameter int               NCLOCK = 10,
  parameter int               CNT_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             running,
  input  logic             finish,
  input  logic [WIDTH-1:0] cut_out,
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] capture_count,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail
);

  localparam logic [CNT_W-1:0] NCLOCK_C = CNT_W'(NCLOCK);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    COMPACT = 3'd2,
    COMPARE = 3'd3,
    RESULT  = 3'd4
  } state_t;

  state_t state_r;
  state_t next_state_s;
  logic   capture_s;
  logic   verdict_r;

  function automatic logic [WIDTH-1:0] misr_next(input logic [WIDTH-1:0] sig,
                                                 input logic [WIDTH-1:0] data);
    logic fb;
    fb = ^(sig & POLY);
    return {sig[WIDTH-2:0], fb} ^ data;
  endfunction

  // Next-state decode; init outranks finish, which outranks running.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (init) next_state_s = ARMED;
        else      next_state_s = IDLE;
      end
      ARMED: begin
        if (init)         next_state_s = ARMED;
        else if (finish)  next_state_s = COMPARE;
        else if (running) next_state_s = COMPACT;
        else              next_state_s = ARMED;
      end
      COMPACT: begin
        if (init)        next_state_s = ARMED;
        else if (finish) next_state_s = COMPARE;
        else             next_state_s = COMPACT;
      end
      COMPARE: begin
        if (init) next_state_s = ARMED;
        else      next_state_s = RESULT;
      end
      RESULT: begin
        if (init) next_state_s = ARMED;
        else      next_state_s = RESULT;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // A running word is compacted only while armed/compacting and never alongside finish or init.
  always_comb begin
    capture_s = 1'b0;
    if ((state_r == ARMED || state_r == COMPACT) && running && !finish && !init) begin
      capture_s = 1'b1;
    end else begin
      capture_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= next_state_s;
  end

  // MISR, capture counter and latched verdict.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      signature     <= SEED;
      capture_count <= {CNT_W{1'b0}};
      verdict_r     <= 1'b0;
    end else if (init) begin
      signature     <= SEED;
      capture_count <= {CNT_W{1'b0}};
      verdict_r     <= 1'b0;
    end else if (capture_s) begin
      signature     <= misr_next(signature, cut_out);
      capture_count <= (capture_count == CNT_MAX) ? capture_count
                                                  : capture_count + CNT_W'(1);
    end else if (state_r == COMPARE) begin
      verdict_r <= (signature == GOLDEN) && (capture_count == NCLOCK_C);
    end
  end

  // Status flags; the verdict is exposed one cycle after it is latched so pass/fail only show with done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      fail <= 1'b0;
    end else begin
      busy <= (next_state_s == ARMED) || (next_state_s == COMPACT);
      done <= (state_r == RESULT) && !init;
      pass <= (state_r == RESULT) && !init && verdict_r;
      fail <= (state_r == RESULT) && !init && !verdict_r;
    end
  end

endmodule

// File: tb/tb_bist_misr_checker.sv
// Directed bench for bist_misr_checker: a phase-level reference model checked every cycle,
// plus literal expectations taken from worked MISR examples.
module tb_bist_misr_checker;

  localparam int         W  = 4;
  localparam int         CW = 3;
  localparam logic [3:0] P  = 4'b1001;
  localparam logic [3:0] S  = 4'b0001;
  localparam logic [3:0] G  = 4'b1110;
  localparam int         NC = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          init = 1'b0, running = 1'b0, finish = 1'b0;
  logic [W-1:0]  cut_out = '0;
  logic [W-1:0]  signature;
  logic [CW-1:0] capture_count;
  logic          busy, done, pass, fail;

  int total = 0;
  int bad = 0;

  bist_misr_checker #(.WIDTH(W), .POLY(P), .SEED(S), .GOLDEN(G), .NCLOCK(NC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .init(init), .running(running), .finish(finish),
    .cut_out(cut_out), .signature(signature), .capture_count(capture_count),
    .busy(busy), .done(done), .pass(pass), .fail(fail)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 accepting words, 2 comparing, 3 verdict pending, 4 reporting.
  int       m_phase = 0;
  int       m_cnt = 0;
  logic [3:0] m_sig = S;
  logic     m_verdict = 1'b0;

  function automatic logic [3:0] model_misr(input logic [3:0] s, input logic [3:0] d);
    int taps;
    logic [3:0] shifted;
    taps = $countones(s & P);
    shifted = (s << 1) | 4'((taps % 2));
    return shifted ^ d;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase <= 0; m_cnt <= 0; m_sig <= S; m_verdict <= 1'b0;
    end else if (init) begin
      m_phase <= 1; m_cnt <= 0; m_sig <= S; m_verdict <= 1'b0;
    end else if (m_phase == 1) begin
      if (finish) m_phase <= 2;
      else if (running) begin
        m_sig <= model_misr(m_sig, cut_out);
        m_cnt <= (m_cnt < 7) ? m_cnt + 1 : 7;
      end
    end else if (m_phase == 2) begin
      m_verdict <= (m_sig == G) && (m_cnt == NC);
      m_phase <= 3;
    end else if (m_phase == 3) begin
      m_phase <= 4;
    end
  end

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    check("model_sig",  int'(signature),     int'(m_sig));
    check("model_cnt",  int'(capture_count), m_cnt);
    check("model_busy", int'(busy),          int'(m_phase == 1));
    check("model_done", int'(done),          int'(m_phase == 4));
    check("model_pass", int'(pass),          int'(m_phase == 4 && m_verdict));
    check("model_fail", int'(fail),          int'(m_phase == 4 && !m_verdict));
  end

  task automatic tick(input logic i, input logic r, input logic f, input logic [3:0] d);
    init = i; running = r; finish = f; cut_out = d;
    @(posedge clk);
    #1;
    init = 1'b0; running = 1'b0; finish = 1'b0; cut_out = 4'h0;
  endtask

  task automatic verdict(input string name, input logic exp_pass);
    tick(1'b0, 1'b0, 1'b0, 4'h0);
    check({name, "_done_early"}, int'(done), 0);
    tick(1'b0, 1'b0, 1'b0, 4'h0);
    check({name, "_done"}, int'(done), 1);
    check({name, "_pass"}, int'(pass), int'(exp_pass));
    check({name, "_fail"}, int'(fail), int'(!exp_pass));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_sig",  int'(signature), 1);
    check("rst_cnt",  int'(capture_count), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b1;
    tick(1'b0, 1'b1, 1'b1, 4'hF);
    check("idle_ignore_busy", int'(busy), 0);

    // Golden run with all-zero responses.
    tick(1'b1, 1'b0, 1'b0, 4'h0);
    check("arm_busy", int'(busy), 1);
    tick(1'b0, 1'b1, 1'b0, 4'h0); check("g_sig1", int'(signature), 4'b0011);
    tick(1'b0, 1'b1, 1'b0, 4'h0); check("g_sig2", int'(signature), 4'b0111);
    tick(1'b0, 1'b1, 1'b0, 4'h0); check("g_sig3", int'(signature), 4'b1111);
    tick(1'b0, 1'b1, 1'b0, 4'h0); check("g_sig4", int'(signature), 4'b1110);
    check("g_cnt", int'(capture_count), 4);
    tick(1'b0, 1'b0, 1'b1, 4'h0);
    verdict("golden", 1'b1);
    tick(1'b0, 1'b1, 1'b1, 4'h5);
    check("result_hold_sig", int'(signature), 4'b1110);

    // Single word of data, count mismatch.
    tick(1'b1, 1'b0, 1'b0, 4'h0);
    check("rearm_done", int'(done), 0);
    tick(1'b0, 1'b1, 1'b0, 4'b0101);
    check("one_sig", int'(signature), 4'b0110);
    check("one_cnt", int'(capture_count), 1);
    tick(1'b0, 1'b0, 1'b1, 4'h0);
    verdict("one", 1'b0);

    // Short run with clean data.
    tick(1'b1, 1'b0, 1'b0, 4'h0);
    repeat (3) tick(1'b0, 1'b1, 1'b0, 4'h0);
    tick(1'b0, 1'b0, 1'b1, 4'h0);
    check("short_cnt", int'(capture_count), 3);
    verdict("short", 1'b0);

    // Abort mid-compaction, then a full rerun.
    tick(1'b1, 1'b0, 1'b0, 4'h0);
    repeat (2) tick(1'b0, 1'b1, 1'b0, 4'h3);
    tick(1'b1, 1'b1, 1'b0, 4'h3);
    check("abort_sig",  int'(signature), 1);
    check("abort_cnt",  int'(capture_count), 0);
    check("abort_busy", int'(busy), 1);
    repeat (4) tick(1'b0, 1'b1, 1'b0, 4'h0);
    tick(1'b0, 1'b0, 1'b1, 4'h0);
    verdict("rerun", 1'b1);

    // Async reset mid-compaction.
    tick(1'b1, 1'b0, 1'b0, 4'h0);
    repeat (2) tick(1'b0, 1'b1, 1'b0, 4'h9);
    #1 reset = 1'b0;
    #1;
    check("areset_sig",  int'(signature), 1);
    check("areset_cnt",  int'(capture_count), 0);
    check("areset_busy", int'(busy), 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    tick(1'b0, 1'b1, 1'b0, 4'h6);
    tick(1'b0, 1'b0, 1'b1, 4'h0);
    tick(1'b0, 1'b0, 1'b0, 4'h0);
    check("post_reset_cnt",  int'(capture_count), 0);
    check("post_reset_done", int'(done), 0);

    // finish together with running: that word is not compacted.
    tick(1'b1, 1'b0, 1'b0, 4'h0);
    repeat (2) tick(1'b0, 1'b1, 1'b0, 4'h0);
    tick(1'b0, 1'b1, 1'b1, 4'hF);
    check("fin_run_sig", int'(signature), 4'b0111);
    check("fin_run_cnt", int'(capture_count), 2);
    verdict("fin_run", 1'b0);

    // init with finish: re-arm wins.
    tick(1'b1, 1'b0, 1'b1, 4'h0);
    check("init_fin_busy", int'(busy), 1);
    tick(1'b0, 1'b0, 1'b0, 4'h0);
    check("init_fin_done", int'(done), 0);

    // Finish straight from ARMED with zero captures.
    tick(1'b0, 1'b0, 1'b1, 4'h0);
    verdict("zero", 1'b0);

    // Counter saturation.
    tick(1'b1, 1'b0, 1'b0, 4'h0);
    repeat (9) tick(1'b0, 1'b1, 1'b0, 4'hA);
    check("sat_cnt", int'(capture_count), 7);
    tick(1'b0, 1'b0, 1'b1, 4'h0);
    verdict("sat", 1'b0);

    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bist_misr_checker.md
Name: bist_misr_checker

Overview:
- Response-compaction and compare stage directly downstream of the BIST controller.
- Consumes the controller's init/running/finish strobes plus the circuit-under-test output word. Compacts that word into a multiple-input signature register (MISR) on every running cycle.
- On finish, compares the signature and capture count against golden values. Drives sticky pass/fail/done until the next init.

Parameters:
WIDTH, 8, width of CUT output word and MISR
POLY, 8'hB8, feedback tap mask; bit i set = sig[i] feeds XOR feedback
SEED, 8'h01, MISR value loaded on init
GOLDEN, 8'h00, expected final signature
NCLOCK, 10, expected number of running cycles (matches controller NCLOCK)
CNT_W, 5, capture counter width; must hold NCLOCK+1

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
init  input  1  controller init strobe; (re)arms checker
running  input  1  controller running qualifier; capture cut_out this cycle
finish  input  1  controller finish strobe; triggers compare
cut_out  input  WIDTH  circuit-under-test response word
signature  output  WIDTH  current MISR contents
capture_count  output  CNT_W  number of cycles compacted since last init
busy  output  1  high in ARMED or COMPACT
done  output  1  high in RESULT
pass  output  1  valid when done; signature==GOLDEN and count==NCLOCK
fail  output  1  valid when done; complement of pass

Behaviour:
- Reset (reset=0, async): state=IDLE, signature=SEED, capture_count=0, busy=done=pass=fail=0. Released synchronously into IDLE.
- Registered state; no output combinationally depends on inputs.
- MISR update, Fibonacci form: fb = ^(signature & POLY); next = {signature[WIDTH-2:0], fb} ^ cut_out.
- States:
  - IDLE: outputs 0. init -> ARMED.
  - ARMED: on entry, signature<=SEED and capture_count<=0 (loaded on the init edge). running -> COMPACT, performing the first update that same edge. finish -> COMPARE.
  - COMPACT: each cycle running=1 -> MISR update, capture_count+1. Counter saturates at all-ones; no wrap. running=0 -> hold values, stay COMPACT. finish -> COMPARE.
  - COMPARE: one cycle. Registers pass<=(signature==GOLDEN)&&(capture_count==NCLOCK), fail<=!that. -> RESULT.
  - RESULT: done=1; pass/fail/signature/capture_count held. Only init leaves (-> ARMED).
- Latency: finish sampled at edge N -> pass/fail/done valid after edge N+2.
- Priority on the same edge: init > finish > running.
  - init during any non-IDLE state aborts the run and re-arms with SEED, clearing done/pass/fail.
  - finish together with running: the running word is NOT compacted.
- running or finish in IDLE or RESULT: ignored, no state change.
- finish in ARMED with zero captures: compare proceeds; fail=1 unless NCLOCK==0.
- Async reset mid-run: immediate return to reset values; a subsequent init is required.
- pass and fail are never both 1; both are 0 whenever done=0.

Test Plan:
- WIDTH=4, POLY=4'b1001, SEED=4'b0001, NCLOCK=4, GOLDEN=4'b1110. Stimulus: init, then 4 cycles running with cut_out=0, then finish. Required: signature 0011, 0111, 1111, 1110; capture_count=4; two edges after finish, done=1, pass=1, fail=0.
- Same config, one running cycle with cut_out=4'b0101 after init -> signature=4'b0110, capture_count=1. finish -> fail=1 (count mismatch).
- Same config, 3 running cycles then finish -> capture_count=3, fail=1 although no data error.
- Mid-COMPACT after 2 captures, assert init -> signature=SEED, capture_count=0, busy=1. Full 4-cycle rerun -> pass=1.
- Drop reset to 0 during COMPACT -> all outputs return to reset values asynchronously, before the next clk edge. running/finish pulses after release do nothing until init.
- finish and running high on the same edge in COMPACT -> signature unchanged by that cut_out, next cycle COMPARE. Separately, init and finish on the same edge -> ARMED, done stays 0.
